load_fanout_skid: RTL and testbench
===================================

LOAD_FANOUT_SKID -- requirements
Module: load_fanout_skid

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every data port.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 in_valid  input  1  SHALL indicate the upstream driver presents valid in_data.
REQ-005 in_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-006 in_data  input  WIDTH  SHALL be the payload from the upstream driver.
REQ-007 ld0_valid / ld1_valid  output  1 each  SHALL indicate head entry offered to load 0 / load 1.
REQ-008 ld0_ready / ld1_ready  input  1 each  SHALL indicate load 0 / load 1 accepts.
REQ-009 ld0_data / ld1_data  output  WIDTH each  SHALL carry the head entry payload.
REQ-010 occupancy  output  2  SHALL report stored entries, 0..2.

Function
REQ-011 Storage SHALL be a 2-entry FIFO: 1-bit head and tail pointers, 2-bit count.
REQ-012 in_ready SHALL equal (count < 2), derived only from registered state, with no combinational path from in_valid or ldN_ready.
REQ-013 Push SHALL occur when in_valid && in_ready; in_data is written at tail, and tail toggles.
REQ-014 ldN_valid SHALL equal (count != 0) && !sentN, where sentN is a per-load flag for the head entry.
REQ-015 ldN_data SHALL equal the head entry, held stable while ldN_valid is high and not accepted.
REQ-016 Load N handshake (ldN_valid && ldN_ready) SHALL set sentN, unless the head retires that cycle.
REQ-017 The head SHALL retire in the cycle where each load is done (sentN already set, or handshake this cycle); on retire, head toggles and sent0/sent1 clear.
REQ-018 Push and retire in the same cycle SHALL leave count unchanged; push alone increments count; retire alone decrements count.
REQ-019 At count 2, in_ready SHALL be 0; no same-cycle pass-through of a retiring slot.
REQ-020 Latency SHALL be 1 cycle: data pushed at edge t into an empty FIFO is on ldN_data with ldN_valid high after edge t.
REQ-021 Loads SHALL be independent: one load may accept entries while the other stalls; the head does not retire until both loads have accepted it.
REQ-022 Pointer wrap (1 -> 0) SHALL be seamless; entry order is strictly preserved.

Reset
REQ-023 While rst_n is low: count=0, head=0, tail=0, sent0=sent1=0, ld0_valid=ld1_valid=0, occupancy=0, in_ready=0.
REQ-024 in_ready SHALL rise in the first cycle after rst_n deasserts; storage contents are not reset.
REQ-025 Reset asserted mid-transfer SHALL discard all entries and sent flags immediately, with no partial delivery after release.

Configuration
REQ-026 Macro LOAD_FANOUT_SKID_PARITY_EN defined SHALL add output ld_par (1 bit) = XOR of the head entry bits, forced 0 when count==0 or in reset.
REQ-027 Macro LOAD_FANOUT_SKID_PARITY_EN undefined SHALL omit the ld_par port and its logic; all other behaviour is identical.

Verification (WIDTH=8)
REQ-028 Reset release, in_valid=1 data 0x5A, both ready=1 -> ld0/ld1_valid high next cycle with 0x5A, retired the following edge, occupancy back to 0.
REQ-029 ld1_ready=0, push 0xA1,0xA2,0xA3 on consecutive cycles -> in_ready low after 2 pushes, occupancy=2; load 0 gets 0xA1 once only; after ld1_ready=1, 0xA1 then 0xA2 retire, then 0xA3 accepted.
REQ-030 Loads accept in different cycles (ld0 at cycle 3, ld1 at cycle 5) -> ld0_valid low cycles 4-5, retire at edge ending cycle 5, no duplicate delivery.
REQ-031 Sustained in_valid, both ready=1, sequence 0x00..0x0F -> one entry per cycle throughout, ordering preserved across pointer wrap, occupancy steady at 1.
REQ-032 rst_n pulled low with occupancy=2 and sent0=1 -> valids drop asynchronously; after release, occupancy=0 and no stale data is offered.
REQ-033 With LOAD_FANOUT_SKID_PARITY_EN, head 0x07 -> ld_par=1; head 0x03 -> ld_par=0; empty -> ld_par=0.

Source files
------------

// File: rtl/load_fanout_skid.sv
// Two-entry FIFO that fans each entry out to two independent loads; an entry retires once both loads took it.
// Optional macro LOAD_FANOUT_SKID_PARITY_EN adds the ld_par output (XOR of the head entry).
module load_fanout_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ld0_valid,
  input  logic             ld0_ready,
  output logic [WIDTH-1:0] ld0_data,
  output logic             ld1_valid,
  input  logic             ld1_ready,
  output logic [WIDTH-1:0] ld1_data,
`ifdef LOAD_FANOUT_SKID_PARITY_EN
  output logic             ld_par,
`endif
  output logic [1:0]       occupancy
);

  function automatic logic par_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [WIDTH-1:0] mem_q [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             sent0_q, sent0_d;
  logic             sent1_q, sent1_d;
  logic             run_q;
  logic             push_s, hs0_s, hs1_s, done0_s, done1_s, retire_s;

  // run_q keeps in_ready low during reset and for the edge that releases it
  assign in_ready  = run_q && (count_q != 2'd2);
  assign ld0_valid = (count_q != 2'd0) && !sent0_q;
  assign ld1_valid = (count_q != 2'd0) && !sent1_q;
  assign ld0_data  = mem_q[head_q];
  assign ld1_data  = mem_q[head_q];
  assign occupancy = count_q;
`ifdef LOAD_FANOUT_SKID_PARITY_EN
  assign ld_par    = (count_q != 2'd0) ? par_f(mem_q[head_q]) : 1'b0;
`endif

  // Handshakes, retire decision and next-state computation
  always_comb begin
    push_s   = in_valid && in_ready;
    hs0_s    = ld0_valid && ld0_ready;
    hs1_s    = ld1_valid && ld1_ready;
    done0_s  = sent0_q || hs0_s;
    done1_s  = sent1_q || hs1_s;
    retire_s = (count_q != 2'd0) && done0_s && done1_s;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    sent0_d  = sent0_q;
    sent1_d  = sent1_q;
    if (retire_s) begin
      head_d  = ~head_q;
      sent0_d = 1'b0;
      sent1_d = 1'b0;
    end else begin
      sent0_d = done0_s;
      sent1_d = done1_s;
    end
    if (push_s) begin
      tail_d = ~tail_q;
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, retire_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      sent0_q <= 1'b0;
      sent1_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sent0_q <= sent0_d;
      sent1_q <= sent1_d;
      run_q   <= 1'b1;
    end
  end

  // Payload storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[tail_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_load_fanout_skid.sv
// Randomized bench for load_fanout_skid: a queue-based reference model is compared every cycle,
// plus directed sequences with literal expectations.
module tb_load_fanout_skid;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       ld0_valid, ld1_valid;
  logic       ld0_ready = 1'b0, ld1_ready = 1'b0;
  logic [7:0] ld0_data, ld1_data;
  logic [1:0] occupancy;
`ifdef LOAD_FANOUT_SKID_PARITY_EN
  logic       ld_par;
`endif

  int vectors = 0;
  int errors  = 0;

  load_fanout_skid #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ld0_valid(ld0_valid), .ld0_ready(ld0_ready), .ld0_data(ld0_data),
    .ld1_valid(ld1_valid), .ld1_ready(ld1_ready), .ld1_data(ld1_data),
`ifdef LOAD_FANOUT_SKID_PARITY_EN
    .ld_par(ld_par),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of stored entries plus "already delivered" per load for the head
  logic [7:0] q[$];
  bit         got0, got1, running;

  always @(negedge clk) begin
    bit ev0, ev1, erdy, push, tk0, tk1;
    if (!rst_n) begin
      q.delete();
      got0 = 0; got1 = 0; running = 0;
    end
    ev0  = (q.size() != 0) && !got0;
    ev1  = (q.size() != 0) && !got1;
    erdy = running && (q.size() < 2);
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("ld0_valid", 32'(ld0_valid), 32'(ev0));
    chk("ld1_valid", 32'(ld1_valid), 32'(ev1));
    if (ev0) chk("ld0_data", 32'(ld0_data), 32'(q[0]));
    if (ev1) chk("ld1_data", 32'(ld1_data), 32'(q[0]));
`ifdef LOAD_FANOUT_SKID_PARITY_EN
    chk("ld_par", 32'(ld_par), (q.size() != 0) ? 32'(^q[0]) : 32'd0);
`endif
    if (rst_n) begin
      push = in_valid && erdy;
      tk0  = got0 || (ev0 && ld0_ready);
      tk1  = got1 || (ev1 && ld1_ready);
      if (q.size() != 0 && tk0 && tk1) begin
        void'(q.pop_front());
        got0 = 0; got1 = 0;
      end else begin
        got0 = tk0; got1 = tk1;
      end
      if (push) q.push_back(in_data);
      running = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset release, single entry 0x5A to both loads
    repeat (3) cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h5A; ld0_ready = 1'b1; ld1_ready = 1'b1;
    chk("release_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("first_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("5A_v0", 32'(ld0_valid), 32'd1);
    chk("5A_v1", 32'(ld1_valid), 32'd1);
    chk("5A_d0", 32'(ld0_data), 32'h5A);
    chk("5A_d1", 32'(ld1_data), 32'h5A);
    cyc();
    chk("5A_retired_occ", 32'(occupancy), 32'd0);

    // Load 1 stalls while three entries are offered
    ld1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; cyc();
    in_data = 8'hA2; cyc();
    in_data = 8'hA3;
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("A1_sent0", 32'(ld0_valid), 32'd0);
    chk("A1_d1", 32'(ld1_data), 32'hA1);
    cyc(); cyc();
    chk("A1_still_once", 32'(ld0_valid), 32'd0);
    ld1_ready = 1'b1; cyc();
    chk("A2_head", 32'(ld0_data), 32'hA2);
    chk("A2_occ", 32'(occupancy), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("A3_head", 32'(ld1_data), 32'hA3);
    cyc();
    chk("A3_done_occ", 32'(occupancy), 32'd0);

    // Loads accept in different cycles
    in_valid = 1'b1; in_data = 8'h33; ld0_ready = 1'b1; ld1_ready = 1'b0; cyc();
    in_valid = 1'b0; cyc();
    chk("split_v0", 32'(ld0_valid), 32'd0);
    chk("split_v1", 32'(ld1_valid), 32'd1);
    cyc();
    chk("split_v0_hold", 32'(ld0_valid), 32'd0);
    ld1_ready = 1'b1; cyc();
    chk("split_done_occ", 32'(occupancy), 32'd0);

    // Sustained stream across pointer wrap
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); cyc();
      if (i > 0) chk("stream_prev_retired", 32'(occupancy), 32'd1);
      chk("stream_d0", 32'(ld0_data), 32'(i));
    end
    in_valid = 1'b0; cyc();

    // Reset while full with load 0 already served
    ld1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB1; cyc();
    in_data = 8'hB2; cyc();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("async_v0", 32'(ld0_valid), 32'd0);
    chk("async_v1", 32'(ld1_valid), 32'd0);
    chk("async_occ", 32'(occupancy), 32'd0);
    cyc(); rst_n = 1'b1; cyc();
    chk("post_rst_v1", 32'(ld1_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

`ifdef LOAD_FANOUT_SKID_PARITY_EN
    ld0_ready = 1'b0; ld1_ready = 1'b0;
    chk("par_empty", 32'(ld_par), 32'd0);
    in_valid = 1'b1; in_data = 8'h07; cyc();
    in_data = 8'h03; cyc();
    in_valid = 1'b0;
    chk("par_07", 32'(ld_par), 32'd1);
    ld0_ready = 1'b1; ld1_ready = 1'b1; cyc();
    chk("par_03", 32'(ld_par), 32'd0);
    cyc();
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = 8'($urandom);
      ld0_ready = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 70 : 30));
      ld1_ready = ($urandom_range(0, 99) < 50);
      rst_n     = !($urandom_range(0, 299) == 0);
      cyc();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
